// File: rtl/window_sum_accumulator.sv
// ---------------------------------------------------------------------------
// window_sum_accumulator
//
// Purpose:
//   Consumes a stream of signed results from the add/multiply stage and sums
//   every WINDOW consecutive results into a signed ACC_W total. The total is
//   handed downstream together with the number of beats it contains and a
//   sticky signed-overflow flag. A flush request closes a partial window.
//
// Ports:
//   clk        in   1         single clock, rising-edge logic
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         in_data holds a valid result
//   in_ready   out  1         block accepts in_data this cycle
//   in_data    in   DATA_W    signed result from upstream
//   flush      in   1         emit the partial window now
//   out_valid  out  1         out_sum/out_count/out_ovf are valid
//   out_ready  in   1         downstream accepts the output this cycle
//   out_sum    out  ACC_W     signed window total (two's-complement wrap)
//   out_count  out  CNT_W     number of beats contained in out_sum
//   out_ovf    out  1         a signed overflow occurred inside the window
// ---------------------------------------------------------------------------
module window_sum_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int WINDOW = 8,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [0:0]       ST_ACCUM = 1'b0;
  localparam logic [0:0]       ST_HOLD  = 1'b1;
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;

  logic             beat;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             close_window;

  // No bypass: while a total is waiting in HOLD, upstream is stalled.
  assign in_ready = (state == ST_ACCUM);
  assign beat     = in_valid && in_ready;

  // Sign-extend the incoming result to the accumulator width.
  assign ext = ACC_W'($signed(in_data));
  assign sum = acc + ext;

  // Signed overflow: both operands share a sign but the result does not.
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // Running values including the beat accepted at this edge, if any.
  assign acc_next = beat ? sum : acc;
  assign cnt_next = beat ? (cnt + CNT_W'(1)) : cnt;
  assign ovf_next = ovf_sticky | (beat & add_ovf);

  // A window closes when it fills, or on flush if it holds at least one beat
  // (counting a beat that arrives together with the flush).
  assign close_window = (state == ST_ACCUM) &&
                        ((beat && (cnt_next == WIN_CNT)) ||
                         (flush && ((cnt != '0) || beat)));

  // Accumulate in ACCUM; on close, latch the total into the output registers
  // and restart the accumulator in the same edge. HOLD keeps the outputs
  // stable until the downstream handshake; output data keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACCUM;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else if (state == ST_ACCUM) begin
      if (close_window) begin
        state      <= ST_HOLD;
        out_valid  <= 1'b1;
        out_sum    <= acc_next;
        out_count  <= cnt_next;
        out_ovf    <= ovf_next;
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= acc_next;
        cnt        <= cnt_next;
        ovf_sticky <= ovf_next;
      end
    end else begin
      if (out_ready) begin
        state     <= ST_ACCUM;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_window_sum_accumulator
//
// Purpose:
//   Drives two accumulators (ACC_W=40 and ACC_W=33, both WINDOW=8) with the
//   same input stream and compares them every cycle against a window model
//   that keeps the accepted beats of the open window in a queue and computes
//   totals and overflow with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_window_sum_accumulator;

  localparam int DATA_W = 32;
  localparam int WINDOW = 8;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready40, in_ready33;
  logic              out_valid40, out_valid33;
  logic [39:0]       out_sum40;
  logic [32:0]       out_sum33;
  logic [CNT_W-1:0]  out_count40, out_count33;
  logic              out_ovf40, out_ovf33;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     win[$];
  bit     m_hold;
  longint e_sum40, e_sum33;
  bit     e_ovf40, e_ovf33;
  int     e_count;

  always #5 clk = ~clk;

  window_sum_accumulator #(.DATA_W(DATA_W), .ACC_W(40), .WINDOW(WINDOW)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready40),
    .in_data(in_data), .flush(flush), .out_valid(out_valid40),
    .out_ready(out_ready), .out_sum(out_sum40), .out_count(out_count40),
    .out_ovf(out_ovf40)
  );

  window_sum_accumulator #(.DATA_W(DATA_W), .ACC_W(33), .WINDOW(WINDOW)) u_dut33 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready33),
    .in_data(in_data), .flush(flush), .out_valid(out_valid33),
    .out_ready(out_ready), .out_sum(out_sum33), .out_count(out_count33),
    .out_ovf(out_ovf33)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Sum the queued window at width w, wrapping like two's complement and
  // flagging any partial sum that leaves the signed range of w bits.
  task automatic windowSum(input int w, output longint bits, output bit ovf);
    longint span, s, t, u;
    span = longint'(1) << w;
    s = 0;
    ovf = 1'b0;
    foreach (win[i]) begin
      t = s + longint'(win[i]);
      if (t > (span / 2) - 1 || t < -(span / 2)) ovf = 1'b1;
      u = t & (span - 1);
      if (u >= span / 2) u = u - span;
      s = u;
    end
    bits = s & (span - 1);
  endtask

  task automatic modelReset();
    win.delete();
    m_hold  = 1'b0;
    e_sum40 = 0;
    e_sum33 = 0;
    e_ovf40 = 1'b0;
    e_ovf33 = 1'b0;
    e_count = 0;
  endtask

  task automatic modelEdge(input bit v, input logic [DATA_W-1:0] d, input bit f,
                           input bit r);
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      if (v) win.push_back(int'(d));
      if ((v && win.size() == WINDOW) || (f && win.size() > 0)) begin
        windowSum(40, e_sum40, e_ovf40);
        windowSum(33, e_sum33, e_ovf33);
        e_count = win.size();
        win.delete();
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid40", 64'(out_valid40), 64'(m_hold));
    checkOutput("out_valid33", 64'(out_valid33), 64'(m_hold));
    checkOutput("out_sum40",   64'(out_sum40),   64'(e_sum40));
    checkOutput("out_sum33",   64'(out_sum33),   64'(e_sum33));
    checkOutput("out_count40", 64'(out_count40), 64'(e_count));
    checkOutput("out_count33", 64'(out_count33), 64'(e_count));
    checkOutput("out_ovf40",   64'(out_ovf40),   64'(e_ovf40));
    checkOutput("out_ovf33",   64'(out_ovf33),   64'(e_ovf33));
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks the
  // combinational ready, advances the model at the rising edge and checks
  // the registered outputs at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d,
                               input bit f, input bit r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    checkOutput("in_ready40", 64'(in_ready40), 64'(!m_hold));
    checkOutput("in_ready33", 64'(in_ready33), 64'(!m_hold));
    @(posedge clk);
    modelEdge(v, d, f, r);
    @(negedge clk);
    checkAll();
  endtask

  // Asserted at a falling edge so the asynchronous clear is visible at once.
  task automatic doReset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("rst_in_ready", 64'(in_ready40), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic beats(input int n, input logic [DATA_W-1:0] d);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, d, 1'b0, 1'b1);
  endtask

  logic [DATA_W-1:0] rd;
  int sel;

  initial begin
    modelReset();
    @(negedge clk);
    doReset();

    // Full window 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b1);
    checkOutput("t1_valid", 64'(out_valid40), 64'd1);
    checkOutput("t1_sum",   64'(out_sum40),   64'd36);
    checkOutput("t1_count", 64'(out_count40), 64'd8);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: output held 5 cycles while upstream keeps offering
    beats(8, 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd99, 1'b0, 1'b0);
    checkOutput("t2_sum", 64'(out_sum40), 64'd24);
    applyStimulus(1'b1, 32'd99, 1'b0, 1'b1);
    beats(8, 32'd1);
    checkOutput("t2_next_sum", 64'(out_sum40), 64'd8);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Flush of a partial window, then a flush with nothing pending
    applyStimulus(1'b1, 32'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, -32'sd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd7, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t3_sum",   64'(out_sum40),   64'd13);
    checkOutput("t3_count", 64'(out_count40), 64'd3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t3_no_out", 64'(out_valid40), 64'd0);

    // Flush together with the third beat includes that beat
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b1);
    checkOutput("t4_sum",   64'(out_sum40),   64'd15);
    checkOutput("t4_count", 64'(out_count40), 64'd3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Overflow at 33 bits, extreme negative sum at 40 bits
    beats(2, 32'h7FFF_FFFF);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    checkOutput("t5_ovf33", 64'(out_ovf33), 64'd1);
    checkOutput("t5_ovf40", 64'(out_ovf40), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    beats(8, 32'h8000_0000);
    checkOutput("t5_sum40", 64'(out_sum40), 64'h00FC_0000_0000);
    checkOutput("t5_neg_ovf40", 64'(out_ovf40), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-window discards the partial window
    beats(4, 32'd9);
    doReset();
    checkOutput("t6_valid", 64'(out_valid40), 64'd0);
    beats(8, 32'd2);
    checkOutput("t6_sum",   64'(out_sum40),   64'd16);
    checkOutput("t6_count", 64'(out_count40), 64'd8);

    // Randomized traffic with extremes, flushes and backpressure
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      rd = 32'h7FFF_FFFF;
      else if (sel == 1) rd = 32'h8000_0000;
      else if (sel < 5)  rd = $urandom;
      else               rd = DATA_W'($urandom_range(0, 200)) - 32'd100;
      if (n == 1500) doReset();
      applyStimulus($urandom_range(0, 9) < 7, rd,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
